// File: rtl/edge_arb_pkg.sv
// Shared types and the round-robin pick helper for the edge event arbiter.
// Sized for the largest supported channel count; callers pass the live count.
package edge_arb_pkg;

    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = 4;

    typedef enum logic [2:0] {
        ZERO = 3'b001,
        EDGE = 3'b010,
        ONE  = 3'b100
    } det_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // First set bit of pending searching from last_grant+1, wrapping at num_ch.
    function automatic logic [MAX_CH_W-1:0] rr_pick(
        input logic [MAX_CH-1:0]   pending,
        input logic [MAX_CH_W-1:0] last_grant,
        input int                  num_ch
    );
        int                  idx;
        logic                found;
        logic [MAX_CH_W-1:0] sel;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= MAX_CH; k++) begin
            if (k <= num_ch) begin
                idx = (int'(last_grant) + k) % num_ch;
                if (!found && pending[idx]) begin
                    sel   = idx[MAX_CH_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/edge_tick_detector.sv
// Three-state rising-edge detector; edge_tick flags the ZERO->EDGE transition
// so the request is registered on the same clock edge as the state move.
module edge_tick_detector
    import edge_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic edge_tick
);

    det_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (!reset) state <= ZERO;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ZERO:    if (level) state_nxt = EDGE;
            EDGE:    state_nxt = level ? ONE : ZERO;
            ONE:     if (!level) state_nxt = ZERO;
            default: state_nxt = ZERO;
        endcase
    end

    assign edge_tick = (state == ZERO) && level;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detectors feeding a round-robin arbiter onto one
// valid/ready event port, with sticky overflow flags and a saturating drop count.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] level,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic [NUM_CH-1:0] overflow,
    input  logic              ovf_clear,
    output logic [CNT_W-1:0]  drop_count,
    output logic              busy
);

    localparam int               SUM_W   = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t          state, state_nxt;
    logic [NUM_CH-1:0]   tick, pending, pending_nxt, new_req, hit, grant_vec, ovf_nxt;
    logic [CH_W-1:0]     last_grant, sel;
    logic [MAX_CH-1:0]   pend_ext;
    logic                avail, grant_en, valid_nxt, busy_nxt;
    logic [SUM_W-1:0]    hit_cnt, drop_base, drop_sum;
    logic [CNT_W-1:0]    drop_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_det
        edge_tick_detector u_det (
            .clk      (clk),
            .reset    (reset),
            .level    (level[i]),
            .edge_tick(tick[i])
        );
    end

    // Channels being disabled this edge are not eligible for a grant.
    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pending & ch_enable;
    end

    assign avail = |(pending & ch_enable);
    assign sel   = CH_W'(rr_pick(pend_ext, MAX_CH_W'(last_grant), NUM_CH));

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            IDLE: begin
                if (avail) begin
                    grant_en  = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (avail) grant_en  = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new edge on a pending, non-granted channel is a lost event.
    always_comb begin
        grant_vec   = grant_en ? (NUM_CH'(1) << sel) : '0;
        new_req     = tick & ch_enable;
        hit         = new_req & pending & ~grant_vec;
        pending_nxt = ch_enable & ((pending & ~grant_vec) | new_req);
        valid_nxt   = (state_nxt == OFFER);
        busy_nxt    = valid_nxt | (|pending_nxt);
        ovf_nxt     = (ovf_clear ? '0 : overflow) | hit;
        hit_cnt     = '0;
        for (int i = 0; i < NUM_CH; i++) hit_cnt = hit_cnt + SUM_W'(hit[i]);
        drop_base   = ovf_clear ? '0 : SUM_W'(drop_count);
        drop_sum    = drop_base + hit_cnt;
        drop_nxt    = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_sum);
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending    <= '0;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            overflow   <= '0;
            drop_count <= '0;
            busy       <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            evt_valid  <= valid_nxt;
            busy       <= busy_nxt;
            overflow   <= ovf_nxt;
            drop_count <= drop_nxt;
            if (grant_en) begin
                evt_ch     <= sel;
                last_grant <= sel;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Cycle-vector table plus hand sequences; accepted events are checked against
// a queue of expected channel numbers filled when the stimulus is driven.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] level = '0;
    logic [3:0] ch_enable = '1;
    logic       evt_ready = 1'b0;
    logic       ovf_clear = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic [3:0] overflow;
    logic [7:0] drop_count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mon_e;

    always #5 clk = ~clk;

    edge_event_arbiter #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .ch_enable (ch_enable),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .drop_count(drop_count),
        .busy      (busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  lvl;
        logic [3:0]  en;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [1:0]  ech;
        logic        eb;
        logic [3:0]  eo;
        logic [7:0]  ed;
        int          np;
        logic [15:0] seq;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t V(input logic rst, input logic [3:0] lvl, input logic [3:0] en,
                               input logic rdy, input logic clr, input logic ev,
                               input logic [1:0] ech, input logic eb, input logic [3:0] eo,
                               input logic [7:0] ed, input int np, input logic [15:0] seq);
        vec_t v;
        v.rst = rst; v.lvl = lvl; v.en = en; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ech = ech; v.eb = eb; v.eo = eo; v.ed = ed;
        v.np = np; v.seq = seq;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int np, input logic [15:0] seq);
        for (int k = 0; k < np; k++) exp_q.push_back(int'(seq[4*k +: 4]));
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset = v.rst; level = v.lvl; ch_enable = v.en;
        evt_ready = v.rdy; ovf_clear = v.clr;
        push_exp(v.np, v.seq);
        step();
        chk("evt_valid", idx, int'(evt_valid), int'(v.ev));
        if (v.ev) chk("evt_ch", idx, int'(evt_ch), int'(v.ech));
        chk("busy", idx, int'(busy), int'(v.eb));
        chk("overflow", idx, int'(overflow), int'(v.eo));
        chk("drop_count", idx, int'(drop_count), int'(v.ed));
    endtask

    task automatic flush(input int tag);
        evt_ready = 1'b1;
        level = '0;
        for (int n = 0; n < 20 && busy; n++) step();
        chk("flush_busy", tag, int'(busy), 0);
        chk("flush_queue_left", tag, exp_q.size(), 0);
    endtask

    // Acceptance happens at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected got ch %0d want none", evt_ch);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e != int'(evt_ch)) begin
                    errors++;
                    $display("FAIL accept_ch got %0d want %0d", evt_ch, mon_e);
                end
            end
        end
    end

    initial begin
        // reset with level[0] high, then one event on ch0 only
        vq.push_back(V(0, 4'h1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(0, 4'h1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 0, 0, 0, 0, 1, 4'h0, 0, 1, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 0, 0, 1, 0, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        // all four rise together: back-to-back 0,1,2,3
        vq.push_back(V(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hF, 4'hF, 1, 0, 0, 0, 1, 4'h0, 0, 4, 16'h3210));
        vq.push_back(V(1, 4'hF, 4'hF, 1, 0, 1, 0, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hF, 4'hF, 1, 0, 1, 1, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hF, 4'hF, 1, 0, 1, 2, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hF, 4'hF, 1, 0, 1, 3, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        // stalled consumer, glitch pulses on ch2
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h4, 4'hF, 0, 0, 0, 0, 1, 4'h0, 0, 1, 16'h2));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 2, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 2, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h4, 4'hF, 0, 0, 1, 2, 1, 4'h0, 0, 1, 16'h2));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 2, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 2, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h4, 4'hF, 0, 0, 1, 2, 1, 4'h4, 1, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 2, 1, 4'h4, 1, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 2, 1, 4'h4, 1, 0, 16'h0));
        vq.push_back(V(1, 4'h4, 4'hF, 0, 0, 1, 2, 1, 4'h4, 2, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 1, 0, 1, 2, 1, 4'h4, 2, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 1, 0, 0, 0, 0, 4'h4, 2, 0, 16'h0));
        // round-robin wrap: last grant ch1, then ch1+ch3 pending -> 3 then 1
        vq.push_back(V(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h2, 4'hF, 1, 0, 0, 0, 1, 4'h0, 0, 1, 16'h1));
        vq.push_back(V(1, 4'h0, 4'hF, 1, 0, 1, 1, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hA, 4'hF, 1, 0, 0, 0, 1, 4'h0, 0, 2, 16'h13));
        vq.push_back(V(1, 4'hA, 4'hF, 1, 0, 1, 3, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hA, 4'hF, 1, 0, 1, 1, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'hA, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        // disabled ch0 ignores its rise; re-enable needs a fresh edge
        vq.push_back(V(1, 4'h0, 4'hE, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hE, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hE, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 1, 0, 0, 0, 1, 4'h0, 0, 1, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 1, 0, 1, 0, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0));
        // ch0 overflow, then clear coinciding with a new overflow
        vq.push_back(V(1, 4'h1, 4'hF, 0, 0, 0, 0, 1, 4'h0, 0, 1, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 0, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 0, 0, 1, 0, 1, 4'h0, 0, 1, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 0, 1, 4'h0, 0, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 0, 0, 1, 0, 1, 4'h1, 1, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 0, 1, 4'h1, 1, 0, 16'h0));
        vq.push_back(V(1, 4'h1, 4'hF, 0, 1, 1, 0, 1, 4'h1, 1, 0, 16'h0));
        vq.push_back(V(1, 4'h0, 4'hF, 0, 0, 1, 0, 1, 4'h1, 1, 0, 16'h0));

        foreach (vq[i]) apply(vq[i], i);

        // 300 more lost edges on ch0 saturate the counter
        for (int n = 0; n < 300; n++) begin
            level = 4'h1; step();
            level = 4'h0; step();
        end
        chk("drop_sat", 100, int'(drop_count), 255);
        chk("ovf_sat", 100, int'(overflow), 1);
        chk("valid_held", 100, int'(evt_valid), 1);
        level = 4'h1; step();
        level = 4'h0; step();
        chk("drop_sat_hold", 101, int'(drop_count), 255);
        ovf_clear = 1'b1; step();
        ovf_clear = 1'b0;
        chk("clr_ovf", 102, int'(overflow), 0);
        chk("clr_drop", 102, int'(drop_count), 0);
        flush(103);

        // two channels overflowing on the same edge add two drops
        evt_ready = 1'b0; level = 4'h0; step();
        level = 4'h6; push_exp(2, 16'h21); step();
        level = 4'h0; step();
        chk("multi_offer_ch", 104, int'(evt_ch), 1);
        level = 4'h6; push_exp(1, 16'h1); step();
        chk("multi_drop1", 105, int'(drop_count), 1);
        chk("multi_ovf1", 105, int'(overflow), 4);
        level = 4'h0; step();
        level = 4'h6; step();
        chk("multi_drop3", 106, int'(drop_count), 3);
        chk("multi_ovf3", 106, int'(overflow), 6);
        flush(107);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
